// File: rtl/csr_hpm_timer.sv
// Counter/timer CSR bank: mcycle, minstret, mhpmcounters, prescaled mtime with compare interrupt.
// Define CSR_HPM_OVERFLOW_IRQ_EN to enable sticky per-counter overflow flags and overflow_intr_o.
module csr_hpm_timer #(
   parameter int unsigned NUM_COUNTERS = 4,
   parameter int unsigned EVENT_W      = 8,
   parameter int unsigned TIMER_DIV    = 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [EVENT_W-1:0] event_i,
   input  logic               csr_ren_i,
   input  logic [11:0]        csr_raddr_i,
   output logic [31:0]        csr_rdata_o,
   output logic               csr_hit_o,
   input  logic [11:0]        csr_waddr_i,
   input  logic [31:0]        csr_wdata_i,
   output logic               timer_intr_o,
   output logic               overflow_intr_o
);

   localparam int unsigned NC = (NUM_COUNTERS > 0) ? NUM_COUNTERS : 1;
   localparam int unsigned PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
   localparam logic [PW-1:0] PRESCALE_LAST = PW'(TIMER_DIV - 1);

   logic [63:0]   mcycle_q, mcycle_d;
   logic [63:0]   minstret_q, minstret_d;
   logic [63:0]   mtime_q, mtime_d;
   logic [63:0]   mtimecmp_q, mtimecmp_d;
   logic [63:0]   hpm_cnt_q [NC];
   logic [63:0]   hpm_cnt_d [NC];
   logic [7:0]    hpm_sel_q [NC];
   logic [7:0]    hpm_sel_d [NC];
   logic [NC-1:0] hpm_of_q, hpm_of_d;
   logic [NC-1:0] hpm_inc;
   logic [31:0]   inhibit_q, inhibit_d;
   logic [PW-1:0] prescale_q, prescale_d;
   logic          prescale_wrap;
   logic          timer_intr_q;
   logic [255:0]  ev_ext;
   logic [63:0]   rd_ctr;

   // A CSR write to either half wins over the increment in the same cycle.
   function automatic logic [63:0] count_step(
      input logic [63:0] cur,
      input logic [11:0] lo_addr,
      input logic [11:0] waddr,
      input logic [31:0] wdata,
      input logic        inc
   );
      if (waddr == lo_addr)            return {cur[63:32], wdata};
      if (waddr == lo_addr + 12'h080)  return {wdata, cur[31:0]};
      return inc ? cur + 64'd1 : cur;
   endfunction

   // NOTE: every variable gets a default at the top of an always_comb, so no path can leave it
   // unassigned and infer a latch.
   always_comb begin
      ev_ext            = '0;
      ev_ext[EVENT_W:1] = event_i;   // bit e is event e; select 0 and > EVENT_W land on zeros

      inhibit_d = inhibit_q;
      if (csr_waddr_i == 12'h320) inhibit_d = {csr_wdata_i[31:2], 1'b0, csr_wdata_i[0]};

      mcycle_d   = count_step(mcycle_q, 12'hB00, csr_waddr_i, csr_wdata_i, !inhibit_q[0]);
      minstret_d = count_step(minstret_q, 12'hB02, csr_waddr_i, csr_wdata_i,
                              event_i[0] && !inhibit_q[2]);

      for (int unsigned n = 0; n < NC; n++) begin
         hpm_inc[n]   = 1'b0;
         hpm_cnt_d[n] = hpm_cnt_q[n];
         hpm_sel_d[n] = hpm_sel_q[n];
         hpm_of_d[n]  = 1'b0;
         if (n < NUM_COUNTERS) begin
            hpm_inc[n]   = ev_ext[hpm_sel_q[n]] && !inhibit_q[5'(n + 3)];
            hpm_cnt_d[n] = count_step(hpm_cnt_q[n], 12'hB03 + 12'(n), csr_waddr_i, csr_wdata_i,
                                      hpm_inc[n]);
            if (csr_waddr_i == 12'h323 + 12'(n)) hpm_sel_d[n] = csr_wdata_i[7:0];
`ifdef CSR_HPM_OVERFLOW_IRQ_EN
            hpm_of_d[n] = hpm_of_q[n];
            if (csr_waddr_i == 12'h323 + 12'(n)) hpm_of_d[n] = csr_wdata_i[31];
            // Only an increment can take an all-ones counter to zero; hardware set wins.
            if ((&hpm_cnt_q[n]) && (hpm_cnt_d[n] == '0)) hpm_of_d[n] = 1'b1;
`endif
         end
      end

      prescale_wrap = (prescale_q == PRESCALE_LAST);
      prescale_d    = prescale_wrap ? '0 : prescale_q + PW'(1);
      mtime_d       = prescale_wrap ? mtime_q + 64'd1 : mtime_q;

      mtimecmp_d = mtimecmp_q;
      if (csr_waddr_i == 12'h7C0) mtimecmp_d[31:0]  = csr_wdata_i;
      if (csr_waddr_i == 12'h7C1) mtimecmp_d[63:32] = csr_wdata_i;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         mcycle_q     <= '0;
         minstret_q   <= '0;
         mtime_q      <= '0;
         mtimecmp_q   <= '1;
         inhibit_q    <= '0;
         prescale_q   <= '0;
         timer_intr_q <= 1'b0;
         hpm_of_q     <= '0;
         // NOTE: these arrays are architectural registers, not RAM, so resetting every entry is
         // intended and maps onto plain flops.
         for (int unsigned n = 0; n < NC; n++) begin
            hpm_cnt_q[n] <= '0;
            hpm_sel_q[n] <= '0;
         end
      end else begin
         mcycle_q     <= mcycle_d;
         minstret_q   <= minstret_d;
         mtime_q      <= mtime_d;
         mtimecmp_q   <= mtimecmp_d;
         inhibit_q    <= inhibit_d;
         prescale_q   <= prescale_d;
         timer_intr_q <= (mtime_q >= mtimecmp_q);
         hpm_of_q     <= hpm_of_d;
         hpm_cnt_q    <= hpm_cnt_d;
         hpm_sel_q    <= hpm_sel_d;
      end
   end

   assign timer_intr_o = timer_intr_q;

`ifdef CSR_HPM_OVERFLOW_IRQ_EN
   logic overflow_intr_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) overflow_intr_q <= 1'b0;
      else         overflow_intr_q <= |hpm_of_q;
   end

   assign overflow_intr_o = overflow_intr_q;
`else
   assign overflow_intr_o = 1'b0;
`endif

   // Counter windows B00-B1F/B80-B9F and C00-C1F/C80-C9F; B01/B81 has no owner.
   always_comb begin
      csr_rdata_o = '0;
      csr_hit_o   = 1'b0;
      rd_ctr      = '0;
      if ((csr_raddr_i[11:8] inside {4'hB, 4'hC}) && (csr_raddr_i[6:5] == 2'b00)) begin
         csr_hit_o = 1'b1;
         case (csr_raddr_i[4:0])
            5'd0: rd_ctr = mcycle_q;
            5'd1: begin
               if (csr_raddr_i[11:8] == 4'hC) rd_ctr = mtime_q;
               else                           csr_hit_o = 1'b0;
            end
            5'd2: rd_ctr = minstret_q;
            default: begin
               for (int unsigned n = 0; n < NUM_COUNTERS; n++)
                  if (csr_raddr_i[4:0] == 5'(n + 3)) rd_ctr = hpm_cnt_q[n];
            end
         endcase
         csr_rdata_o = csr_raddr_i[7] ? rd_ctr[63:32] : rd_ctr[31:0];
      end else if (csr_raddr_i[11:5] == 7'h19) begin
         csr_hit_o = (csr_raddr_i[4:0] != 5'd1) && (csr_raddr_i[4:0] != 5'd2);
         if (csr_raddr_i[4:0] == 5'd0) csr_rdata_o = inhibit_q;
         for (int unsigned n = 0; n < NUM_COUNTERS; n++)
            if (csr_raddr_i[4:0] == 5'(n + 3)) csr_rdata_o = {hpm_of_q[n], 23'd0, hpm_sel_q[n]};
      end else if (csr_raddr_i == 12'h7C0) begin
         csr_hit_o   = 1'b1;
         csr_rdata_o = mtimecmp_q[31:0];
      end else if (csr_raddr_i == 12'h7C1) begin
         csr_hit_o   = 1'b1;
         csr_rdata_o = mtimecmp_q[63:32];
      end
      if (!csr_ren_i) begin
         csr_rdata_o = '0;
         csr_hit_o   = 1'b0;
      end
   end

endmodule

// File: tb/tb_csr_hpm_timer.sv
// Scoreboard bench for csr_hpm_timer (NUM_COUNTERS = 2, EVENT_W = 8, TIMER_DIV = 4).
module tb_csr_hpm_timer;

   localparam int unsigned NUM_COUNTERS = 2;
   localparam int unsigned EVENT_W      = 8;
   localparam int unsigned TIMER_DIV    = 4;

   logic               clk_i = 1'b0;
   logic               rst_ni;
   logic [EVENT_W-1:0] event_i;
   logic               csr_ren_i;
   logic [11:0]        csr_raddr_i;
   logic [31:0]        csr_rdata_o;
   logic               csr_hit_o;
   logic [11:0]        csr_waddr_i;
   logic [31:0]        csr_wdata_i;
   logic               timer_intr_o;
   logic               overflow_intr_o;

   csr_hpm_timer #(
      .NUM_COUNTERS (NUM_COUNTERS),
      .EVENT_W      (EVENT_W),
      .TIMER_DIV    (TIMER_DIV)
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .event_i         (event_i),
      .csr_ren_i       (csr_ren_i),
      .csr_raddr_i     (csr_raddr_i),
      .csr_rdata_o     (csr_rdata_o),
      .csr_hit_o       (csr_hit_o),
      .csr_waddr_i     (csr_waddr_i),
      .csr_wdata_i     (csr_wdata_i),
      .timer_intr_o    (timer_intr_o),
      .overflow_intr_o (overflow_intr_o)
   );

   always #5 clk_i = ~clk_i;

   typedef enum logic [1:0] {K_READ, K_IDLE, K_TIMER, K_OVF} kind_t;
   typedef struct {
      kind_t       kind;
      string       name;
      logic [31:0] data;
      logic        bit_v;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   logic probe  = 1'b0;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input kind_t kind, input string name, input logic [31:0] data,
                       input logic bit_v);
      exp_t e;
      e.kind  = kind;
      e.name  = name;
      e.data  = data;
      e.bit_v = bit_v;
      sb_q.push_back(e);
   endtask

   task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] data,
                     input logic hit);
      push(K_READ, name, data, hit);
      csr_ren_i   = 1'b1;
      csr_raddr_i = addr;
      tick();
      csr_ren_i   = 1'b0;
   endtask

   task automatic look(input kind_t kind, input string name, input logic bit_v);
      push(kind, name, 32'd0, bit_v);
      csr_raddr_i = 12'hB00;
      probe       = 1'b1;
      tick();
      probe       = 1'b0;
   endtask

   task automatic wr(input logic [11:0] addr, input logic [31:0] data);
      csr_waddr_i = addr;
      csr_wdata_i = data;
      tick();
      csr_waddr_i = 12'h000;
   endtask

   task automatic pulse(input logic [EVENT_W-1:0] ev);
      event_i = ev;
      tick();
      event_i = '0;
   endtask

   // Monitor: one expectation is consumed per cycle in which the DUT is asked for an output.
   always @(negedge clk_i) begin
      if (csr_ren_i || probe) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_sample: no expectation queued at %0t", $time);
         end else begin
            mon_e = sb_q.pop_front();
            case (mon_e.kind)
               K_READ, K_IDLE: begin
                  if (csr_rdata_o !== mon_e.data || csr_hit_o !== mon_e.bit_v) begin
                     errors++;
                     $display("FAIL %s: got rdata=%h hit=%b, want rdata=%h hit=%b", mon_e.name,
                              csr_rdata_o, csr_hit_o, mon_e.data, mon_e.bit_v);
                  end
               end
               K_TIMER: begin
                  if (timer_intr_o !== mon_e.bit_v) begin
                     errors++;
                     $display("FAIL %s: got timer_intr_o=%b, want %b", mon_e.name, timer_intr_o,
                              mon_e.bit_v);
                  end
               end
               default: begin
                  if (overflow_intr_o !== mon_e.bit_v) begin
                     errors++;
                     $display("FAIL %s: got overflow_intr_o=%b, want %b", mon_e.name,
                              overflow_intr_o, mon_e.bit_v);
                  end
               end
            endcase
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_ni      = 1'b0;
      event_i     = '0;
      csr_ren_i   = 1'b0;
      csr_raddr_i = 12'h000;
      csr_waddr_i = 12'h000;
      csr_wdata_i = 32'h0;
      tick();
      tick();

      // Reset state and idle counting
      look(K_TIMER, "rst_timer_intr", 1'b0);
      look(K_OVF, "rst_ovf_intr", 1'b0);
      rst_ni = 1'b1;
      repeat (10) tick();
      rd("idle_mcycle", 12'hB00, 32'd10, 1'b1);
      rd("idle_minstret", 12'hB02, 32'd0, 1'b1);
      rd("rst_mtimecmp_lo", 12'h7C0, 32'hFFFF_FFFF, 1'b1);
      rd("rst_mtimecmp_hi", 12'h7C1, 32'hFFFF_FFFF, 1'b1);
      look(K_TIMER, "idle_timer_intr", 1'b0);

      // Mid-operation reset, then timer compare with TIMER_DIV = 4
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      rd("mcycle_after_rst", 12'hB00, 32'd0, 1'b1);
      wr(12'h7C1, 32'h0);
      wr(12'h7C0, 32'd3);
      repeat (9) tick();
      look(K_TIMER, "timer_before_3", 1'b0);
      look(K_TIMER, "timer_at_3", 1'b1);
      rd("time_alias", 12'hC01, 32'd3, 1'b1);
      wr(12'h7C0, 32'hFFFF_FFFF);
      look(K_TIMER, "timer_hold_1cyc", 1'b1);
      look(K_TIMER, "timer_cleared", 1'b0);

      // Event selection, inhibit and minstret
      wr(12'h323, 32'd2);
      repeat (5) pulse(8'h02);
      repeat (3) pulse(8'h04);
      rd("hpm3_lo_count", 12'hB03, 32'd5, 1'b1);
      rd("hpm3_hi_count", 12'hB83, 32'd0, 1'b1);
      rd("hpmevent3", 12'h323, 32'd2, 1'b1);
      wr(12'h320, 32'h0000_000A);
      repeat (2) pulse(8'h02);
      rd("hpm3_inhibited", 12'hB03, 32'd5, 1'b1);
      rd("inhibit_bit1_zero", 12'h320, 32'h0000_0008, 1'b1);
      repeat (3) pulse(8'h01);
      rd("minstret_count", 12'hB02, 32'd3, 1'b1);
      wr(12'h320, 32'h0);
      wr(12'h323, 32'h7FFF_FF09);
      rd("hpmevent_mid_zero", 12'h323, 32'd9, 1'b1);
      repeat (2) pulse(8'hFF);
      rd("hpm3_sel_oob", 12'hB03, 32'd5, 1'b1);
      rd("hpm4_sel_zero", 12'hC04, 32'd0, 1'b1);

      // 64-bit carry and write-beats-increment
      wr(12'hB80, 32'h0);
      wr(12'hB00, 32'hFFFF_FFFE);
      rd("mcycle_written", 12'hB00, 32'hFFFF_FFFE, 1'b1);
      tick();
      rd("mcycle_carry_hi", 12'hB80, 32'd1, 1'b1);
      rd("mcycle_carry_lo", 12'hB00, 32'd1, 1'b1);
      wr(12'hB00, 32'd7);
      rd("write_wins", 12'hB00, 32'd7, 1'b1);
      rd("count_after_write", 12'hB00, 32'd8, 1'b1);
      rd("hi_held", 12'hB80, 32'd1, 1'b1);

      // Decode boundaries and read-only aliases
      rd("no_hit_7ff", 12'h7FF, 32'd0, 1'b0);
      rd("unimpl_c05", 12'hC05, 32'd0, 1'b1);
      rd("hpm3_alias", 12'hC03, 32'd5, 1'b1);
      rd("no_hit_b01", 12'hB01, 32'd0, 1'b0);
      wr(12'hC00, 32'd5);
      rd("c_write_ignored", 12'hB00, 32'd15, 1'b1);
      look(K_IDLE, "ren_low_quiet", 1'b0);
      rd("no_hit_321", 12'h321, 32'd0, 1'b0);

`ifdef CSR_HPM_OVERFLOW_IRQ_EN
      wr(12'h323, 32'd1);
      wr(12'hB83, 32'hFFFF_FFFF);
      wr(12'hB03, 32'hFFFF_FFFF);
      pulse(8'h01);
      rd("wrap_lo", 12'hB03, 32'd0, 1'b1);
      rd("wrap_hi", 12'hB83, 32'd0, 1'b1);
      rd("of_bit_set", 12'h323, 32'h8000_0001, 1'b1);
      look(K_OVF, "ovf_intr_set", 1'b1);
      wr(12'h323, 32'd1);
      tick();
      look(K_OVF, "ovf_intr_clear", 1'b0);
`else
      wr(12'h323, 32'h8000_0001);
      rd("of_bit_ignored", 12'h323, 32'd1, 1'b1);
      wr(12'hB83, 32'hFFFF_FFFF);
      wr(12'hB03, 32'hFFFF_FFFF);
      pulse(8'h01);
      rd("wrap_lo", 12'hB03, 32'd0, 1'b1);
      rd("wrap_hi", 12'hB83, 32'd0, 1'b1);
      rd("of_bit_stays_0", 12'h323, 32'd1, 1'b1);
      look(K_OVF, "ovf_intr_tied", 1'b0);
`endif

      repeat (2) tick();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
